// File: rtl/vector_sequencer.sv
// Sweeps a fixed 8-entry 5-bit stimulus table into a downstream logic stage and logs its Y response.
// Optional self-check (err_cnt/pass) is enabled by defining VECTOR_SEQUENCER_CHECK_EN.
module vector_sequencer #(
   parameter logic [7:0] EXP_Y = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic [7:0] dwell,
   input  logic       Y,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic       E,
   output logic       busy,
   output logic       done,
   output logic [2:0] vec_idx,
   output logic [7:0] y_log
`ifdef VECTOR_SEQUENCER_CHECK_EN
   ,
   output logic [3:0] err_cnt,
   output logic       pass
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t     state, state_nxt;
   logic [7:0] dw_q, cnt, dw_eff;
   logic [4:0] stim;
   logic       launch, step, last;

   function automatic logic [4:0] vec_lut(input logic [2:0] i);
      case (i)
         3'd0:    vec_lut = 5'b00000;
         3'd1:    vec_lut = 5'b10101;
         3'd2:    vec_lut = 5'b11011;
         3'd3:    vec_lut = 5'b11111;
         3'd4:    vec_lut = 5'b01010;
         3'd5:    vec_lut = 5'b11100;
         3'd6:    vec_lut = 5'b00111;
         default: vec_lut = 5'b10000;
      endcase
   endfunction

   assign dw_eff = (dwell == 8'd0) ? 8'd1 : dwell;
   assign launch = (state == IDLE) && start;
   // A capture happens on the last unpaused cycle of each vector's dwell.
   assign step   = (state == RUN) && !pause && (cnt == 8'd0);
   assign last   = step && (vec_idx == 3'd7);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dw_q    <= 8'd0;
         cnt     <= 8'd0;
         vec_idx <= 3'd0;
         y_log   <= 8'd0;
         stim    <= 5'd0;
      end else if (launch) begin
         dw_q    <= dw_eff;
         cnt     <= dw_eff - 8'd1;
         vec_idx <= 3'd0;
         y_log   <= 8'd0;
         stim    <= vec_lut(3'd0);
      end else if (state == RUN && !pause) begin
         if (cnt == 8'd0) begin
            y_log[vec_idx] <= Y;
            cnt            <= dw_q - 8'd1;
            if (vec_idx == 3'd7) begin
               stim <= 5'd0;
            end else begin
               vec_idx <= vec_idx + 3'd1;
               stim    <= vec_lut(vec_idx + 3'd1);
            end
         end else begin
            cnt <= cnt - 8'd1;
         end
      end
   end

   assign {A, B, C, D, E} = stim;
   assign busy = (state == RUN);
   assign done = (state == FIN);

`ifdef VECTOR_SEQUENCER_CHECK_EN
   logic [3:0] err_nxt;

   always_comb begin
      err_nxt = err_cnt;
      if (launch)
         err_nxt = 4'd0;
      else if (step && (Y != EXP_Y[vec_idx]) && (err_cnt != 4'd15))
         err_nxt = err_cnt + 4'd1;
   end

   // pass is decided on the final capture so it is valid as FIN begins.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= 4'd0;
         pass    <= 1'b0;
      end else begin
         err_cnt <= err_nxt;
         if (launch)    pass <= 1'b0;
         else if (last) pass <= (err_nxt == 4'd0);
      end
   end
`endif

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: per-cycle expected outputs are queued at launch and popped each cycle.
module tb_vector_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, pause, y;
   logic [7:0] dwell;
   logic       sa, sb, sc, sd, se, busy, done;
   logic [2:0] vec_idx;
   logic [7:0] y_log;
   int         ymode;
   int         checks = 0;
   int         errors = 0;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [2:0] idx;
      logic [4:0] vec;
   } obs_t;

   obs_t exp_q[$];

   localparam logic [4:0] TBL [8] = '{5'b00000, 5'b10101, 5'b11011, 5'b11111,
                                      5'b01010, 5'b11100, 5'b00111, 5'b10000};

`ifdef VECTOR_SEQUENCER_CHECK_EN
   logic [3:0] err_cnt, err_cnt2;
   logic       pass, pass2;
   logic       a2, b2, c2, d2, e2, busy2, done2;
   logic [2:0] vec_idx2;
   logic [7:0] y_log2;
`endif

   vector_sequencer #(.EXP_Y(8'hFF)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .dwell(dwell), .Y(y),
      .A(sa), .B(sb), .C(sc), .D(sd), .E(se),
      .busy(busy), .done(done), .vec_idx(vec_idx), .y_log(y_log)
`ifdef VECTOR_SEQUENCER_CHECK_EN
      , .err_cnt(err_cnt), .pass(pass)
`endif
   );

`ifdef VECTOR_SEQUENCER_CHECK_EN
   vector_sequencer #(.EXP_Y(8'h00)) dut2 (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .dwell(dwell), .Y(y),
      .A(a2), .B(b2), .C(c2), .D(d2), .E(e2),
      .busy(busy2), .done(done2), .vec_idx(vec_idx2), .y_log(y_log2),
      .err_cnt(err_cnt2), .pass(pass2)
   );
`endif

   always #5 clk = ~clk;

   assign y = (ymode == 2) ? (sa & se) : (ymode == 1);

   function automatic obs_t mk(input logic b, input logic d, input int i, input logic [4:0] v);
      obs_t o;
      o.busy = b;
      o.done = d;
      o.idx  = i[2:0];
      o.vec  = v;
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full sweep; pause window is plen cycles starting pat cycles into vector pv,
   // poke pulses start and changes dwell to 5 at RUN cycle 'poke'.
   task automatic sweep(input logic [7:0] dw, input int pv, input int pat, input int plen,
                        input int poke, input logic [7:0] exp_log);
      int   d, n, p0;
      obs_t o;
      d = (dw == 8'd0) ? 1 : int'(dw);
      exp_q.delete();
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < d + ((k == pv) ? plen : 0); j++)
            exp_q.push_back(mk(1'b1, 1'b0, k, TBL[k]));
      exp_q.push_back(mk(1'b0, 1'b1, 7, 5'd0));
      n  = exp_q.size();
      p0 = pv * d + pat;
      @(negedge clk);
      start = 1'b1;
      dwell = dw;
      @(negedge clk);
      start = 1'b0;
      for (int cy = 0; cy < n; cy++) begin
         o = exp_q.pop_front();
         chk("cycle", {22'd0, busy, done, vec_idx, sa, sb, sc, sd, se}, {22'd0, o});
         pause = (cy >= p0) && (cy < p0 + plen);
         start = (cy == poke);
         if (cy == poke) dwell = 8'd5;
         if (cy == n - 1) chk("ylog_fin", {24'd0, y_log}, {24'd0, exp_log});
         @(negedge clk);
      end
      pause = 1'b0;
      start = 1'b0;
      chk("idle_out", {25'd0, busy, done, sa, sb, sc, sd, se}, 32'd0);
      chk("ylog_hold", {24'd0, y_log}, {24'd0, exp_log});
   endtask

   initial begin
      obs_t o;
      rst = 1'b1; start = 1'b0; pause = 1'b0; dwell = 8'd0; ymode = 0;
      repeat (2) @(negedge clk);
      chk("reset_out", {22'd0, busy, done, vec_idx, sa, sb, sc, sd, se}, 32'd0);
      chk("reset_ylog", {24'd0, y_log}, 32'd0);
      rst = 1'b0;

      ymode = 1;
      sweep(8'd2, -1, 0, 0, -1, 8'hFF);
      ymode = 2;
      sweep(8'd0, -1, 0, 0, -1, 8'b0000_1110);
      ymode = 1;
      sweep(8'd3, 2, 1, 5, -1, 8'hFF);

      // abort during vector 4 with dwell 2
      exp_q.delete();
      for (int k = 0; k < 5; k++)
         for (int j = 0; j < ((k == 4) ? 1 : 2); j++)
            exp_q.push_back(mk(1'b1, 1'b0, k, TBL[k]));
      @(negedge clk);
      start = 1'b1;
      dwell = 8'd2;
      @(negedge clk);
      start = 1'b0;
      for (int cy = 0; cy < 9; cy++) begin
         o = exp_q.pop_front();
         chk("abort_cycle", {22'd0, busy, done, vec_idx, sa, sb, sc, sd, se}, {22'd0, o});
         if (cy == 8) rst = 1'b1;
         @(negedge clk);
      end
      chk("abort_out", {22'd0, busy, done, vec_idx, sa, sb, sc, sd, se}, 32'd0);
      chk("abort_ylog", {24'd0, y_log}, 32'd0);
      rst = 1'b0;
      for (int cy = 0; cy < 4; cy++) begin
         chk("abort_nodone", {31'd0, done}, 32'd0);
         @(negedge clk);
      end

      sweep(8'd2, -1, 0, 0, 3, 8'hFF);

`ifdef VECTOR_SEQUENCER_CHECK_EN
      ymode = 0;
      sweep(8'd1, -1, 0, 0, -1, 8'h00);
      chk("err_cnt_ff", {28'd0, err_cnt}, 32'd8);
      chk("pass_ff", {31'd0, pass}, 32'd0);
      chk("err_cnt_00", {28'd0, err_cnt2}, 32'd0);
      chk("pass_00", {31'd0, pass2}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
